// File: rtl/hazard_stall_unit.sv
// Stall/bubble controller for the 5-stage MIPS pipeline: load-use, ID-branch and mult/div occupancy.
// Optional stall-cycle performance counter is built when HAZARD_PERF_EN is defined.
module hazard_stall_unit #(
  parameter int MD_LATENCY = 4,
  parameter int MD_CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_RS,
  input  logic [4:0] ID_RT,
  input  logic       ID_UsesRT,
  input  logic       ID_Branch,
  input  logic       ID_MD_Start,
  input  logic       ID_MD_Read,
  input  logic [4:0] EX_WriteReg,
  input  logic       EX_RegWrite,
  input  logic       EX_MemtoReg,
  input  logic [4:0] EX_MEM_WriteReg,
  input  logic       EX_MEM_RegWrite,
  input  logic       EX_MEM_MemtoReg,
  output logic       Stall_F,
  output logic       Stall_D,
  output logic       Flush_E,
  output logic [1:0] Stall_Cause,
  output logic       MD_Busy
`ifdef HAZARD_PERF_EN
  ,output logic [31:0] Stall_Cycles
`endif
);

  typedef enum logic {MD_IDLE, MD_RUN} md_state_t;

  md_state_t             md_state;
  logic [MD_CNT_W-1:0]   md_cnt;
  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic lw_hz, br_hz, md_hz, stall, accept;

  // Register $0 never carries a real dependency.
  assign rs_ex  = (EX_WriteReg != 5'd0) && (EX_WriteReg == ID_RS);
  assign rt_ex  = (EX_WriteReg != 5'd0) && ID_UsesRT && (EX_WriteReg == ID_RT);
  assign rs_mem = (EX_MEM_WriteReg != 5'd0) && (EX_MEM_WriteReg == ID_RS);
  assign rt_mem = (EX_MEM_WriteReg != 5'd0) && ID_UsesRT && (EX_MEM_WriteReg == ID_RT);

  assign lw_hz = EX_MemtoReg && EX_RegWrite && (rs_ex || rt_ex);
  assign br_hz = ID_Branch && ((EX_RegWrite && (rs_ex || rt_ex)) ||
                               (EX_MEM_RegWrite && EX_MEM_MemtoReg && (rs_mem || rt_mem)));
  assign md_hz = (ID_MD_Start || ID_MD_Read) && (md_cnt != '0);

  assign stall   = !reset && (lw_hz || br_hz || md_hz);
  assign Stall_F = stall;
  assign Stall_D = stall;
  assign Flush_E = stall;
  assign accept  = ID_MD_Start && !stall;

  always_comb begin
    Stall_Cause = 2'b00;
    if (!reset) begin
      if (lw_hz)      Stall_Cause = 2'b01;
      else if (br_hz) Stall_Cause = 2'b10;
      else if (md_hz) Stall_Cause = 2'b11;
    end
  end

  // Occupancy FSM; md_hz keeps accept out of MD_RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
      MD_Busy  <= 1'b0;
    end else begin
      case (md_state)
        MD_IDLE: if (accept) begin
          md_state <= MD_RUN;
          md_cnt   <= MD_CNT_W'(MD_LATENCY);
          MD_Busy  <= 1'b1;
        end
        MD_RUN: begin
          md_cnt <= md_cnt - MD_CNT_W'(1);
          if (md_cnt == MD_CNT_W'(1)) begin
            md_state <= MD_IDLE;
            MD_Busy  <= 1'b0;
          end
        end
        default: begin
          md_state <= MD_IDLE;
          md_cnt   <= '0;
          MD_Busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)                              Stall_Cycles <= '0;
    else if (stall && Stall_Cycles != '1)   Stall_Cycles <= Stall_Cycles + 32'd1;
  end
`endif

endmodule
